// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E integer core (no loads/stores).
// Each instruction walks FETCH_INSTR -> WAIT_INSTR -> FETCH_REGS -> EXECUTE.
// Retired register writes are reported one cycle later on the wb_* port.
// SYSTEM instructions halt the core cleanly. Unsupported encodings halt it
// with trap raised.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter int          ADDR_WIDTH = 24,
    parameter int          NREGS      = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rbusy,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  trap
);

    // Bank index width: 16 registers for RV32E, 32 for RV32I.
    localparam int IDX_W = (NREGS == 16) ? 4 : 5;
    localparam logic [5:0] NREGS_L = 6'(NREGS);
    localparam logic [31:0] NOP = 32'h0000_0013;  // ADDI x0,x0,0
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = {RESET_ADDR[ADDR_WIDTH-1:2], 2'b00};
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH_INSTR,
        WAIT_INSTR,
        FETCH_REGS,
        EXECUTE,
        HALT
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [31:0]           instr_reg;
    logic                  wb_valid_reg;
    logic [4:0]            wb_rd_reg;
    logic [31:0]           wb_data_reg;
    logic                  halted_reg;
    logic                  trap_reg;
    logic                  fetch_strobe;

    // Register bank: plain array with registered reads so it maps to RAM.
    logic [31:0] regs [NREGS];
    logic [31:0] rs1_raw_reg;
    logic [31:0] rs2_raw_reg;

    // ---------------------------------------------------------------
    // Instruction field decode
    // ---------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] i_imm, b_imm, u_imm, j_imm;

    assign opcode   = instr_reg[6:0];
    assign rd       = instr_reg[11:7];
    assign funct3   = instr_reg[14:12];
    assign rs1      = instr_reg[19:15];
    assign rs2      = instr_reg[24:20];
    assign funct7_5 = instr_reg[30];

    assign i_imm = {{20{instr_reg[31]}}, instr_reg[31:20]};
    assign b_imm = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                    instr_reg[30:25], instr_reg[11:8], 1'b0};
    assign u_imm = {instr_reg[31:12], 12'b0};
    assign j_imm = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                    instr_reg[20], instr_reg[30:21], 1'b0};

    logic is_alu_reg, is_alu_imm, is_lui, is_auipc, is_jal, is_jalr;
    logic is_branch, is_system;

    assign is_alu_reg = (opcode == OP_ALU_REG);
    assign is_alu_imm = (opcode == OP_ALU_IMM);
    assign is_lui     = (opcode == OP_LUI);
    assign is_auipc   = (opcode == OP_AUIPC);
    assign is_jal     = (opcode == OP_JAL);
    assign is_jalr    = (opcode == OP_JALR);
    assign is_branch  = (opcode == OP_BRANCH);
    assign is_system  = (opcode == OP_SYSTEM);

    // Legality: only register fields the format actually uses are range-checked.
    logic uses_rs1, uses_rs2, writes_rd, known_op, bad_index, bad_branch, illegal;

    assign uses_rs1   = is_alu_reg | is_alu_imm | is_jalr | is_branch;
    assign uses_rs2   = is_alu_reg | is_branch;
    assign writes_rd  = is_alu_reg | is_alu_imm | is_lui | is_auipc | is_jal | is_jalr;
    assign known_op   = writes_rd | is_branch;
    assign bad_index  = (uses_rs1  && ({1'b0, rs1} >= NREGS_L)) ||
                        (uses_rs2  && ({1'b0, rs2} >= NREGS_L)) ||
                        (writes_rd && ({1'b0, rd}  >= NREGS_L));
    assign bad_branch = is_branch && (funct3[2:1] == 2'b01);
    assign illegal    = !is_system && (!known_op || bad_index || bad_branch);

    // x0 is masked here rather than stored, so the bank needs no reset.
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rs1_raw_reg;
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rs2_raw_reg;

    // ---------------------------------------------------------------
    // ALU
    // ---------------------------------------------------------------
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_out;

    assign alu_b = is_alu_reg ? rs2_val : i_imm;
    assign shamt = is_alu_reg ? rs2_val[4:0] : instr_reg[24:20];

    // Integer ALU shared by register and immediate forms; SUB only for reg form.
    always_comb begin
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = (is_alu_reg && funct7_5) ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001: alu_out = rs1_val << shamt;
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = funct7_5 ? 32'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
            3'b110: alu_out = rs1_val | alu_b;
            3'b111: alu_out = rs1_val & alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    // Branch condition evaluation.
    logic take_branch;
    always_comb begin
        take_branch = 1'b0;
        case (funct3)
            3'b000: take_branch = (rs1_val == rs2_val);
            3'b001: take_branch = (rs1_val != rs2_val);
            3'b100: take_branch = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: take_branch = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: take_branch = (rs1_val <  rs2_val);
            3'b111: take_branch = (rs1_val >= rs2_val);
            default: take_branch = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // Next PC and write-back value
    // ---------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [31:0]           jalr_sum;
    logic [31:0]           result;

    assign pc_plus4 = pc_reg + PC_STEP;
    assign jalr_sum = rs1_val + i_imm;

    // Select next PC and result; all PC sums wrap at ADDR_WIDTH bits.
    always_comb begin
        pc_next = pc_plus4;
        result  = alu_out;
        if (is_lui) begin
            result = u_imm;
        end else if (is_auipc) begin
            result = 32'(pc_reg) + u_imm;
        end else if (is_jal) begin
            pc_next = pc_reg + j_imm[ADDR_WIDTH-1:0];
            result  = 32'(pc_plus4);
        end else if (is_jalr) begin
            pc_next = {jalr_sum[ADDR_WIDTH-1:2], 2'b00};
            result  = 32'(pc_plus4);
        end else if (is_branch && take_branch) begin
            pc_next = pc_reg + b_imm[ADDR_WIDTH-1:0];
        end
    end

    logic do_write;
    assign do_write = (state_reg == EXECUTE) && !is_system && !illegal &&
                      writes_rd && (rd != 5'd0);

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------

    // State register; reset restarts at the fetch of RESET_ADDR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= FETCH_INSTR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and fetch strobe.
    always_comb begin
        state_next   = state_reg;
        fetch_strobe = 1'b0;
        case (state_reg)
            FETCH_INSTR: begin
                fetch_strobe = 1'b1;
                state_next   = WAIT_INSTR;
            end
            WAIT_INSTR: begin
                if (!mem_rbusy) begin
                    state_next = FETCH_REGS;
                end
            end
            FETCH_REGS: state_next = EXECUTE;
            EXECUTE:    state_next = (is_system || illegal) ? HALT : FETCH_INSTR;
            HALT:       state_next = HALT;
            default:    state_next = HALT;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------

    // Instruction latch, PC update, write-back report and halt flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= 5'd0;
            wb_data_reg  <= 32'd0;
            halted_reg   <= 1'b0;
            trap_reg     <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            case (state_reg)
                WAIT_INSTR: begin
                    if (!mem_rbusy) begin
                        instr_reg <= mem_rdata;
                    end
                end
                EXECUTE: begin
                    if (is_system) begin
                        halted_reg <= 1'b1;
                        trap_reg   <= 1'b0;
                    end else if (illegal) begin
                        halted_reg <= 1'b1;
                        trap_reg   <= 1'b1;
                    end else begin
                        pc_reg <= pc_next;
                        if (do_write) begin
                            wb_valid_reg <= 1'b1;
                            wb_rd_reg    <= rd;
                            wb_data_reg  <= result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register bank: write at end of EXECUTE, operand reads in FETCH_REGS.
    always_ff @(posedge clk) begin
        if (resetn && do_write) begin
            regs[rd[IDX_W-1:0]] <= result;
        end
        if (state_reg == FETCH_REGS) begin
            rs1_raw_reg <= regs[rs1[IDX_W-1:0]];
            rs2_raw_reg <= regs[rs2[IDX_W-1:0]];
        end
    end

    // Strobe is masked while reset is held so none escapes during reset.
    assign mem_rstrb = fetch_strobe & resetn;
    assign mem_addr  = pc_reg;
    assign pc        = pc_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;
    assign halted    = halted_reg;
    assign trap      = trap_reg;

endmodule

// File: doc/rv32_multicycle_core.md
RV32_MULTICYCLE_CORE -- requirements
Module: rv32_multicycle_core

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0, PC value loaded on reset.
REQ-002 Parameter ADDR_WIDTH, default 24, width of mem_addr and of the PC; legal range 8..32.
REQ-003 Parameter NREGS, default 32, register count; legal values 32 (RV32I) or 16 (RV32E).
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 mem_addr  out  ADDR_WIDTH  instruction fetch byte address, bits [1:0] always 0.
REQ-007 mem_rstrb  out  1  one-cycle fetch request strobe.
REQ-008 mem_rdata  in  32  instruction word; valid in any WAIT_INSTR cycle with mem_rbusy=0.
REQ-009 mem_rbusy  in  1  memory stall; core waits while high.
REQ-010 wb_valid  out  1  one-cycle pulse when a register write retires.
REQ-011 wb_rd  out  5  destination register of the retiring write.
REQ-012 wb_data  out  32  value written.
REQ-013 pc  out  ADDR_WIDTH  current PC.
REQ-014 halted  out  1  core stopped; held until reset.
REQ-015 trap  out  1  halt caused by unsupported or illegal instruction.

Function
REQ-016 States SHALL be FETCH_INSTR, WAIT_INSTR, FETCH_REGS, EXECUTE, HALT.
REQ-017 FETCH_INSTR: mem_rstrb=1 and mem_addr=pc for exactly one cycle; next state WAIT_INSTR.
REQ-018 WAIT_INSTR: stay while mem_rbusy=1; when mem_rbusy=0, latch mem_rdata into instr and go to FETCH_REGS.
REQ-019 FETCH_REGS: read rs1/rs2 from register bank; x0 always reads 0; next state EXECUTE.
REQ-020 EXECUTE: compute result, write back, update PC; next state FETCH_INSTR, or HALT per REQ-027/028.
REQ-021 An instruction with zero-wait memory SHALL take exactly 4 cycles; each mem_rbusy cycle adds one.
REQ-022 Supported: ALU reg (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), ALU imm incl. SLLI/SRLI/SRAI, LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, ECALL/EBREAK.
REQ-023 SUB only when funct7[5]=1 and opcode is ALU reg; ADDI with imm bit 10 set stays ADD.
REQ-024 Shift amount: rs2[4:0] for reg form, instr[24:20] for imm form; SRA/SRAI arithmetic when funct7[5]=1.
REQ-025 Next PC: pc+4 by default; pc+Bimm if branch taken; pc+Jimm for JAL; (rs1+Iimm) with bits [1:0] forced 0 for JALR; all modulo 2^ADDR_WIDTH.
REQ-026 JAL/JALR write pc+4 (zero-extended to 32 bits) to rd; LUI writes Uimm; AUIPC writes pc+Uimm.
REQ-027 SYSTEM opcode SHALL go to HALT with halted=1, trap=0, no write-back, pc unchanged.
REQ-028 LOAD, STORE, FENCE, any other opcode, or any rs1/rs2/rd index >= NREGS SHALL go to HALT with halted=1, trap=1, no write-back.
REQ-029 Writes to rd=0 SHALL be discarded and SHALL NOT pulse wb_valid.
REQ-030 wb_valid pulses in the cycle after EXECUTE, with wb_rd/wb_data stable that cycle; 0 otherwise.
REQ-031 HALT is absorbing: no mem_rstrb, no wb_valid, until resetn=0.

Reset
REQ-032 On resetn=0 at a clock edge: pc=RESET_ADDR, state=FETCH_INSTR, instr=NOP (ADDI x0,x0,0), mem_rstrb=0, wb_valid=0, halted=0, trap=0.
REQ-033 Reset in any state, including mid-stall in WAIT_INSTR or in HALT, SHALL abort the instruction with no write-back.
REQ-034 Register bank x1..x(NREGS-1) contents are undefined after reset; the bench SHALL initialise them to 0 only in simulation.

Verification
REQ-035 ADDI x1,x0,5; ADD x2,x1,x1; SUB x3,x0,x2 -> wb pulses x1=5, x2=10, x3=32'hFFFFFFF6, 4 cycles apart.
REQ-036 x1=32'h80000000; SRAI x2,x1,4; SRLI x3,x1,4 -> x2=32'hF8000000, x3=32'h08000000.
REQ-037 At pc=0x10: BNE x0,x1,-8 with x1=1 -> next fetch mem_addr=0x08; same with x1=0 -> 0x14.
REQ-038 At pc=0x20: JAL x1,+0x100 -> wb x1=0x24, next mem_addr=0x120; JALR x0,x1,3 -> next mem_addr=0x24.
REQ-039 mem_rbusy held high 3 cycles after strobe -> instruction retires at cycle 7; resetn low during stall -> no wb_valid, next strobe at RESET_ADDR.
REQ-040 EBREAK -> halted=1, trap=0, no further strobes; word 32'h00002003 (LW) -> halted=1, trap=1; NREGS=16 with ADDI x20,x0,1 -> trap=1.
